// File: rtl/rv0_fcsr.sv
// Floating-point CSR block: fflags/frm/fcsr access with a fixed one-cycle response,
// flag accrual from the FP ALU and mstatus.FS state tracking.
module rv0_fcsr (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        csr_req_i,
  input  logic [11:0] csr_addr_i,
  input  logic [1:0]  csr_op_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_ready_o,
  output logic        csr_ack_o,
  output logic [31:0] csr_rdata_o,
  output logic        csr_err_o,
  input  logic        fflags_valid_i,
  input  logic [4:0]  fflags_i,
  input  logic        fpr_we_i,
  input  logic        fs_wr_i,
  input  logic [1:0]  fs_wdata_i,
  output logic [2:0]  frm_o,
  output logic        frm_invalid_o,
  output logic [1:0]  fs_o
);

  localparam logic [0:0]  IDLE        = 1'b0;
  localparam logic [0:0]  RESP        = 1'b1;
  localparam logic [11:0] ADDR_FFLAGS = 12'h001;
  localparam logic [11:0] ADDR_FRM    = 12'h002;
  localparam logic [11:0] ADDR_FCSR   = 12'h003;
  localparam logic [1:0]  OP_RD       = 2'b00;
  localparam logic [1:0]  OP_RW       = 2'b01;
  localparam logic [1:0]  OP_RS       = 2'b10;
  localparam logic [1:0]  FS_OFF      = 2'b00;
  localparam logic [1:0]  FS_INIT     = 2'b01;
  localparam logic [1:0]  FS_DIRTY    = 2'b11;

  function automatic logic [31:0] csr_update(input logic [1:0] op, input logic [31:0] old,
                                             input logic [31:0] wdata);
    case (op)
      OP_RW:   csr_update = wdata;
      OP_RS:   csr_update = old | wdata;
      OP_RD:   csr_update = old;
      default: csr_update = old & ~wdata;
    endcase
  endfunction

  logic [0:0]  state;
  logic [4:0]  fflags, fflags_nxt;
  logic [2:0]  frm, frm_nxt;
  logic [1:0]  fs, fs_nxt;
  logic        ack_p1, err_p1;
  logic [31:0] rdata_p1;
  logic [31:0] old_val, wr_val;
  logic        addr_ok, fs_off, accept, fault, do_write, accrue;
  logic        unused_wr_hi;

  always_comb begin
    old_val = '0;
    addr_ok = 1'b1;
    case (csr_addr_i)
      ADDR_FFLAGS: old_val = {27'b0, fflags};
      ADDR_FRM:    old_val = {29'b0, frm};
      ADDR_FCSR:   old_val = {24'b0, frm, fflags};
      default:     addr_ok = 1'b0;
    endcase
  end

  assign fs_off       = (fs == FS_OFF);
  assign accept       = (state == IDLE) && csr_req_i;
  assign fault        = !addr_ok || fs_off;
  assign do_write     = accept && !fault && (csr_op_i != OP_RD);
  assign accrue       = fflags_valid_i && !fs_off;
  assign wr_val       = csr_update(csr_op_i, old_val, csr_wdata_i);
  // Fields are at most 8 bits wide; the upper write result is deliberately dropped.
  assign unused_wr_hi = ^wr_val[31:8];

  always_comb begin
    fflags_nxt = fflags;
    frm_nxt    = frm;
    if (do_write) begin
      case (csr_addr_i)
        ADDR_FFLAGS: fflags_nxt = wr_val[4:0];
        ADDR_FRM:    frm_nxt    = wr_val[2:0];
        ADDR_FCSR:   {frm_nxt, fflags_nxt} = wr_val[7:0];
        default:     ;
      endcase
    end
    // Accrued flags are OR-ed after the CSR write so they survive a same-edge clear.
    if (accrue) fflags_nxt = fflags_nxt | fflags_i;
    fs_nxt = fs;
    if (fs_wr_i)
      fs_nxt = fs_wdata_i;
    else if (do_write || (accrue && (fflags_i != 5'b0)) || (fpr_we_i && !fs_off))
      fs_nxt = FS_DIRTY;
  end

  // Stage p1: response registers, one cycle after acceptance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      fflags   <= '0;
      frm      <= '0;
      fs       <= FS_INIT;
      ack_p1   <= 1'b0;
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      state    <= accept ? RESP : IDLE;
      fflags   <= fflags_nxt;
      frm      <= frm_nxt;
      fs       <= fs_nxt;
      ack_p1   <= accept;
      err_p1   <= accept && fault;
      rdata_p1 <= (accept && !fault) ? old_val : '0;
    end
  end

  assign csr_ready_o   = (state == IDLE);
  assign csr_ack_o     = ack_p1;
  assign csr_err_o     = err_p1;
  assign csr_rdata_o   = rdata_p1;
  assign frm_o         = frm;
  assign frm_invalid_o = frm[2] & (frm[1] | frm[0]);
  assign fs_o          = fs;

endmodule
